// File: rtl/obstacle_scheduler_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | obstacle_scheduler_pkg                                             |
// | Shared game constants: screen geometry, field widths, LFSR setup,  |
// | scheduler FSM encoding and the LFSR step function.                 |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package obstacle_scheduler_pkg;

   localparam int SCREEN_W = 640;
   localparam int CACTUS_W = 60;
   localparam int POS_W    = 10;
   localparam int SPEED_W  = 4;

   localparam logic [15:0] LFSR_SEED = 16'hACE1;
   // Taps 16,14,13,11 expressed as bit positions 15,13,12,10
   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WALK  = 2'd1,
      ST_SPAWN = 2'd2
   } state_t;

   // One Fibonacci step: XOR of tapped bits shifts in at the bottom
   function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
      return {cur[14:0], ^(cur & LFSR_TAPS)};
   endfunction

endpackage
`default_nettype wire

// File: rtl/obstacle_scheduler_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | obstacle_scheduler_if                                              |
// | Game-state inputs and per-slot obstacle outputs of the scheduler.  |
// | master = scheduler side, slave = game logic / renderer side.       |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
interface obstacle_scheduler_if #(
   parameter int N_SLOTS = 3
);
   import obstacle_scheduler_pkg::*;

   logic                       game_status;
   logic                       fresh;
   logic [POS_W*N_SLOTS-1:0]   obs_pos;
   logic [N_SLOTS-1:0]         obs_active;
   logic [SPEED_W-1:0]         speed;
   logic                       spawn_pulse;
   logic                       busy;

   modport master (
      input  game_status,
      input  fresh,
      output obs_pos,
      output obs_active,
      output speed,
      output spawn_pulse,
      output busy
   );

   modport slave (
      output game_status,
      output fresh,
      input  obs_pos,
      input  obs_active,
      input  speed,
      input  spawn_pulse,
      input  busy
   );

endinterface
`default_nettype wire

// File: rtl/obstacle_scheduler_lfsr16.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | lfsr16                                                             |
// | 16-bit Fibonacci LFSR with step enable and seed load. Seeded with  |
// | a non-zero value so it never locks up at zero.                     |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module lfsr16
   import obstacle_scheduler_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        step,
   input  logic        load,
   output logic [15:0] q
);

   // Seed on reset or load, otherwise advance one step when enabled
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q <= LFSR_SEED;
      end else if (load) begin
         q <= LFSR_SEED;
      end else if (step) begin
         q <= lfsr_next(q);
      end
   end

endmodule
`default_nettype wire

// File: rtl/obstacle_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | obstacle_scheduler                                                 |
// | Per-frame cactus slot scheduler: advances live slots by the scroll |
// | speed, retires off-screen slots, spawns new ones after a random    |
// | gap and ramps the scroll speed over time.                          |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module obstacle_scheduler
   import obstacle_scheduler_pkg::*;
#(
   parameter int N_SLOTS     = 3,
   parameter int SPEED_INIT  = 4,
   parameter int RAMP_FRAMES = 512,
   parameter int MIN_GAP     = 40,
   parameter int RETIRE_POS  = 700
) (
   input  logic                  clk,
   input  logic                  RESET,
   obstacle_scheduler_if.master  bus
);

   localparam int IDX_W = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1;
   localparam int FC_W  = (RAMP_FRAMES > 1) ? $clog2(RAMP_FRAMES) : 1;
   // Wide enough for MIN_GAP plus the largest 6-bit random extension
   localparam int GAP_W = 10;

   localparam logic [IDX_W-1:0]   LAST_IDX    = IDX_W'(N_SLOTS - 1);
   localparam logic [SPEED_W-1:0] SPEED_RESET = SPEED_W'(SPEED_INIT);
   localparam logic [SPEED_W-1:0] SPEED_MAX   = '1;
   localparam logic [GAP_W-1:0]   GAP_RESET   = GAP_W'(MIN_GAP);
   localparam logic [FC_W-1:0]    FRAME_LAST  = FC_W'(RAMP_FRAMES - 1);
   localparam logic [POS_W:0]     RETIRE      = (POS_W + 1)'(RETIRE_POS);

   state_t              state;
   logic [IDX_W-1:0]    idx;
   logic [POS_W-1:0]    pos [N_SLOTS];
   logic [N_SLOTS-1:0]  active;
   logic [SPEED_W-1:0]  speed;
   logic [GAP_W-1:0]    gap_cnt;
   logic [FC_W-1:0]     frame_cnt;
   logic                fresh_q;
   logic                spawn_pulse;
   logic                busy;

   logic [15:0]         lfsr;
   logic                lfsr_unused;
   logic                tick;
   logic [POS_W:0]      sum;
   logic                any_free;
   logic [IDX_W-1:0]    free_idx;

   lfsr16 u_lfsr (
      .clk   (clk),
      .rst_n (RESET),
      .step  (state == ST_SPAWN),
      .load  (1'b0),
      .q     (lfsr)
   );

   // Only the low six bits feed the spawn gap
   assign lfsr_unused = ^lfsr[15:6];

   // Falling edge of the frame strobe; ignored while a walk is running
   assign tick = fresh_q & ~bus.fresh & ~busy;

   // Full 11-bit sum so a slot near the top of the range can never wrap
   assign sum = {1'b0, pos[idx]} + (POS_W + 1)'(speed);

   // Lowest-index free slot for the spawn decision
   always_comb begin
      any_free = 1'b0;
      free_idx = '0;
      for (int i = N_SLOTS - 1; i >= 0; i--) begin
         if (!active[i]) begin
            any_free = 1'b1;
            free_idx = IDX_W'(i);
         end
      end
   end

   // Frame FSM: walk slots, spawn, ramp speed; a game stop clears everything
   always_ff @(posedge clk or negedge RESET) begin
      if (!RESET) begin
         state       <= ST_IDLE;
         idx         <= '0;
         for (int i = 0; i < N_SLOTS; i++) begin
            pos[i] <= '0;
         end
         active      <= '0;
         speed       <= SPEED_RESET;
         gap_cnt     <= GAP_RESET;
         frame_cnt   <= '0;
         fresh_q     <= 1'b0;
         spawn_pulse <= 1'b0;
         busy        <= 1'b0;
      end else begin
         fresh_q     <= bus.fresh;
         spawn_pulse <= 1'b0;
         if (!bus.game_status) begin
            state     <= ST_IDLE;
            idx       <= '0;
            for (int i = 0; i < N_SLOTS; i++) begin
               pos[i] <= '0;
            end
            active    <= '0;
            speed     <= SPEED_RESET;
            gap_cnt   <= GAP_RESET;
            frame_cnt <= '0;
            busy      <= 1'b0;
         end else begin
            unique case (state)
               ST_IDLE: begin
                  if (tick) begin
                     state <= ST_WALK;
                     idx   <= '0;
                     busy  <= 1'b1;
                  end
               end
               ST_WALK: begin
                  if (active[idx]) begin
                     if (sum >= RETIRE) begin
                        active[idx] <= 1'b0;
                        pos[idx]    <= '0;
                     end else begin
                        pos[idx]    <= sum[POS_W-1:0];
                     end
                  end
                  if (idx == LAST_IDX) begin
                     state <= ST_SPAWN;
                  end else begin
                     idx <= idx + 1'b1;
                  end
               end
               ST_SPAWN: begin
                  if (gap_cnt == '0 && any_free) begin
                     active[free_idx] <= 1'b1;
                     pos[free_idx]    <= '0;
                     spawn_pulse      <= 1'b1;
                     gap_cnt          <= GAP_RESET + GAP_W'(lfsr[5:0]);
                  end else if (gap_cnt != '0) begin
                     gap_cnt <= gap_cnt - 1'b1;
                  end
                  if (frame_cnt == FRAME_LAST) begin
                     frame_cnt <= '0;
                     if (speed != SPEED_MAX) begin
                        speed <= speed + 1'b1;
                     end
                  end else begin
                     frame_cnt <= frame_cnt + 1'b1;
                  end
                  state <= ST_IDLE;
                  busy  <= 1'b0;
               end
               default: begin
                  state <= ST_IDLE;
                  busy  <= 1'b0;
               end
            endcase
         end
      end
   end

   for (genvar g = 0; g < N_SLOTS; g++) begin : g_pos_out
      assign bus.obs_pos[g*POS_W +: POS_W] = pos[g];
   end

   assign bus.obs_active  = active;
   assign bus.speed       = speed;
   assign bus.spawn_pulse = spawn_pulse;
   assign bus.busy        = busy;

endmodule
`default_nettype wire

// File: tb/tb_obstacle_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_obstacle_scheduler                                              |
// | Frame-level scoreboard bench for obstacle_scheduler: each issued   |
// | frame pushes its expected result, a monitor pops and compares it   |
// | when busy falls. Directed checks cover spawn gap, retire, abort    |
// | and speed saturation.                                              |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_obstacle_scheduler;
   import obstacle_scheduler_pkg::*;

   localparam int N = 3;

   logic clk   = 1'b0;
   logic RESET = 1'b0;

   obstacle_scheduler_if #(.N_SLOTS(N)) bus();

   obstacle_scheduler #(
      .N_SLOTS     (N),
      .SPEED_INIT  (4),
      .RAMP_FRAMES (512),
      .MIN_GAP     (40),
      .RETIRE_POS  (700)
   ) dut (
      .clk   (clk),
      .RESET (RESET),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [29:0] pos;
      logic [2:0]  act;
      logic [3:0]  speed;
      logic        sp;
   } exp_t;

   exp_t exp_q[$];
   int   checks   = 0;
   int   failures = 0;

   // Frame-level reference state
   int          m_pos [N];
   logic [2:0]  m_act;
   int          m_speed;
   int          m_gap;
   int          m_frame;
   logic [15:0] m_lfsr;

   task automatic check(input string name, input logic [31:0] actual, input logic [31:0] required);
      checks++;
      if (actual !== required) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", name, actual, required);
      end
   endtask

   task automatic push_expect(input logic sp);
      exp_t e;
      e.pos   = {10'(m_pos[2]), 10'(m_pos[1]), 10'(m_pos[0])};
      e.act   = m_act;
      e.speed = 4'(m_speed);
      e.sp    = sp;
      exp_q.push_back(e);
   endtask

   // Expected result of one accepted frame tick
   task automatic model_frame();
      int   s;
      logic sp;
      logic done;
      logic fb;
      for (int i = 0; i < N; i++) begin
         if (m_act[i]) begin
            s = m_pos[i] + m_speed;
            if (s >= 700) begin
               m_act[i] = 1'b0;
               m_pos[i] = 0;
            end else begin
               m_pos[i] = s;
            end
         end
      end
      sp = 1'b0;
      if (m_gap == 0 && m_act != 3'b111) begin
         done = 1'b0;
         for (int i = 0; i < N; i++) begin
            if (!done && !m_act[i]) begin
               m_act[i] = 1'b1;
               m_pos[i] = 0;
               done     = 1'b1;
            end
         end
         sp    = 1'b1;
         m_gap = 40 + int'(m_lfsr[5:0]);
      end else if (m_gap != 0) begin
         m_gap--;
      end
      fb     = m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10];
      m_lfsr = {m_lfsr[14:0], fb};
      if (m_frame == 511) begin
         m_frame = 0;
         if (m_speed < 15) m_speed++;
      end else begin
         m_frame++;
      end
      push_expect(sp);
   endtask

   task automatic model_clear();
      for (int i = 0; i < N; i++) m_pos[i] = 0;
      m_act   = 3'b000;
      m_speed = 4;
      m_gap   = 40;
      m_frame = 0;
   endtask

   // One frame strobe; optionally re-strobe while the walk is running
   task automatic do_tick(input bit toggle_busy);
      @(negedge clk) bus.fresh = 1'b1;
      model_frame();
      @(negedge clk) bus.fresh = 1'b0;
      if (toggle_busy) begin
         @(negedge clk) bus.fresh = 1'b1;
         @(negedge clk) bus.fresh = 1'b0;
      end
      repeat (6) @(negedge clk);
   endtask

   // Monitor: compare against the scoreboard whenever a frame update ends
   initial begin : monitor
      logic busy_q;
      exp_t e;
      busy_q = 1'b0;
      forever begin
         @(negedge clk);
         if (busy_q && !bus.busy) begin
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_frame actual=busy_fall required=none");
            end else begin
               e = exp_q.pop_front();
               check("frame_obs_pos", 32'(bus.obs_pos), 32'(e.pos));
               check("frame_obs_active", 32'(bus.obs_active), 32'(e.act));
               check("frame_speed", 32'(bus.speed), 32'(e.speed));
               check("frame_spawn_pulse", 32'(bus.spawn_pulse), 32'(e.sp));
            end
         end
         busy_q = bus.busy;
      end
   end

   initial begin : watchdog
      #1_500_000;
      failures++;
      $display("FAIL watchdog actual=timeout required=finish");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog expired");
   end

   initial begin : stimulus
      bus.game_status = 1'b0;
      bus.fresh       = 1'b0;
      model_clear();
      m_lfsr = 16'hACE1;

      repeat (3) @(negedge clk);
      check("reset_obs_pos", 32'(bus.obs_pos), 32'd0);
      check("reset_obs_active", 32'(bus.obs_active), 32'd0);
      check("reset_speed", 32'(bus.speed), 32'd4);
      check("reset_spawn_pulse", 32'(bus.spawn_pulse), 32'd0);
      check("reset_busy", 32'(bus.busy), 32'd0);
      bus.game_status = 1'b1;
      @(negedge clk) RESET = 1'b1;
      repeat (2) @(negedge clk);

      // Gap counter starts at 40: ticks 1..40 spawn nothing, tick 41 spawns slot 0
      repeat (40) do_tick(1'b0);
      check("no_spawn_40_ticks", 32'(bus.obs_active), 32'd0);
      do_tick(1'b0);
      check("spawn_41_active", 32'(bus.obs_active), 32'd1);
      check("spawn_41_pos0", 32'(bus.obs_pos[9:0]), 32'd0);

      // Slot 0 moves 4 px per frame: 173 frames -> 692, then 696, then retired
      repeat (173) do_tick(1'b0);
      check("slot0_pos_692", 32'(bus.obs_pos[9:0]), 32'd692);
      check("slot0_active_692", 32'(bus.obs_active[0]), 32'd1);
      do_tick(1'b0);
      check("slot0_pos_696", 32'(bus.obs_pos[9:0]), 32'd696);
      check("slot0_active_696", 32'(bus.obs_active[0]), 32'd1);
      do_tick(1'b0);
      check("slot0_retired_pos", 32'(bus.obs_pos[9:0]), 32'd0);

      // Long enough for the pool to fill, saturate the gap and recycle slots
      repeat (300) do_tick(1'b0);

      // Stop the game on the second walk cycle
      @(negedge clk) bus.fresh = 1'b1;
      @(negedge clk) bus.fresh = 1'b0;
      @(negedge clk);
      @(negedge clk) bus.game_status = 1'b0;
      model_clear();
      push_expect(1'b0);
      @(negedge clk) bus.game_status = 1'b1;
      check("abort_busy", 32'(bus.busy), 32'd0);
      check("abort_obs_active", 32'(bus.obs_active), 32'd0);
      check("abort_obs_pos", 32'(bus.obs_pos), 32'd0);
      check("abort_speed", 32'(bus.speed), 32'd4);
      repeat (4) @(negedge clk);

      // Strobes while busy must not add frames; ramp counting depends on it
      repeat (3) do_tick(1'b1);
      repeat (5628) do_tick(1'b0);
      check("speed_before_last_step", 32'(bus.speed), 32'd14);
      do_tick(1'b0);
      check("speed_saturated", 32'(bus.speed), 32'd15);
      repeat (20) do_tick(1'b0);
      check("speed_holds_15", 32'(bus.speed), 32'd15);

      repeat (5) @(negedge clk);
      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
